// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift sequencers.
// Provides:
//   seq_state_t  - three-state sequencer FSM encoding (IDLE / SHIFT / GAP)
//   LSB_FIRST, MSB_FIRST - bit-order selectors for the shift register
//   cnt_width()  - counter width helper, never narrower than one bit
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_t;

  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

  // Width of a counter that must hold values 0..n-1. A counter that only
  // ever holds 0 still needs one physical bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, serial-out shift register.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high clear
//   load  in   capture din (takes priority over shift)
//   shift in   advance one position toward the output end, filling with 0
//   din   in   WIDTH parallel word
//   sout  out  current serial bit (bit 0 when DIR=LSB_FIRST, bit WIDTH-1
//              when DIR=MSB_FIRST); comes straight from a flop
// Zeros are shifted in behind the data, so after WIDTH shifts the register
// is empty and sout idles low without any extra gating.
module piso_shreg #(
  parameter int WIDTH = 8,
  parameter int DIR   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);
  import serial_pkg::*;

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] shifted;

  // Per-bit neighbour selection for a one-position move toward the output end.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (DIR == MSB_FIRST) begin : g_up
        if (gi == 0) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = data_reg[gi-1];
        end
      end else begin : g_down
        if (gi == WIDTH - 1) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = data_reg[gi+1];
        end
      end
    end
  endgenerate

  always_comb begin
    data_next = data_reg;
    if (load) begin
      data_next = din;
    end else if (shift) begin
      data_next = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_next;
    end
  end

  generate
    if (DIR == MSB_FIRST) begin : g_out_msb
      assign sout = data_reg[WIDTH-1];
    end else begin : g_out_lsb
      assign sout = data_reg[0];
    end
  endgenerate

endmodule

// File: rtl/serial_tx_sequencer.sv
// Word-to-serial transmit sequencer.
// Accepts a parallel word over a valid/ready handshake while idle, then
// presents it one bit per clock with a qualifying enable and frame flag,
// followed by GAP idle cycles before the next word may be accepted.
// Parameters:
//   WIDTH     bits per frame (>= 2)
//   GAP       idle cycles after each frame (>= 0)
//   MSB_FIRST 0: bit 0 first, 1: bit WIDTH-1 first
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   din          in   word to send
//   din_valid    in   producer has a word
//   din_ready    out  word accepted this cycle (decoded from state only)
//   shift_out    out  serial data bit (registered)
//   shift_en     out  shift_out carries a frame bit (registered)
//   frame_active out  high for all WIDTH bit cycles (registered)
//   done         out  one-cycle pulse with the last bit (registered)
module serial_tx_sequencer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             shift_out,
  output logic             shift_en,
  output logic             frame_active,
  output logic             done
);
  import serial_pkg::*;

  localparam int CW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP + 1);

  localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_PENULT = CW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? GAP - 1 : 0);

  seq_state_t    state_reg;
  logic [CW-1:0] bit_cnt_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic          shift_en_reg;
  logic          frame_active_reg;
  logic          done_reg;

  logic          load;
  logic          shift;

  // Accepting in IDLE loads the word; the first bit is then visible on the
  // register output in the very next cycle. Every SHIFT cycle advances one
  // position, including the last one, which drains the register to zero.
  assign load  = (state_reg == ST_IDLE) && din_valid;
  assign shift = (state_reg == ST_SHIFT);

  piso_shreg #(
    .WIDTH (WIDTH),
    .DIR   (MSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (din),
    .sout  (shift_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      bit_cnt_reg      <= '0;
      gap_cnt_reg      <= '0;
      shift_en_reg     <= 1'b0;
      frame_active_reg <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (din_valid) begin
            state_reg        <= ST_SHIFT;
            bit_cnt_reg      <= '0;
            shift_en_reg     <= 1'b1;
            frame_active_reg <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (bit_cnt_reg == BIT_LAST) begin
            shift_en_reg     <= 1'b0;
            frame_active_reg <= 1'b0;
            done_reg         <= 1'b0;
            gap_cnt_reg      <= '0;
            if (GAP > 0) begin
              state_reg <= ST_GAP;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            // done is registered, so raise it one edge ahead of the last bit.
            done_reg    <= (bit_cnt_reg == BIT_PENULT);
          end
        end

        ST_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg        <= ST_IDLE;
          shift_en_reg     <= 1'b0;
          frame_active_reg <= 1'b0;
          done_reg         <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready    = (state_reg == ST_IDLE);
  assign shift_en     = shift_en_reg;
  assign frame_active = frame_active_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Directed bench for serial_tx_sequencer. Four instances cover the
// parameter sets: 0 = GAP 1 LSB-first, 1 = GAP 1 MSB-first,
// 2 = GAP 2 LSB-first, 3 = GAP 0 LSB-first.
module tb_serial_tx_sequencer;

  localparam int NDUT = 4;
  localparam int GAPS [NDUT] = '{1, 1, 2, 0};
  localparam int MSBS [NDUT] = '{0, 1, 0, 0};

  logic       clk;
  logic       rst;
  logic [7:0] din_s   [NDUT];
  logic       valid_s [NDUT];
  logic       ready_s [NDUT];
  logic       so_s    [NDUT];
  logic       en_s    [NDUT];
  logic       fa_s    [NDUT];
  logic       dn_s    [NDUT];

  int n_cmp;
  int n_bad;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      serial_tx_sequencer #(
        .WIDTH     (8),
        .GAP       (GAPS[gi]),
        .MSB_FIRST (MSBS[gi])
      ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din_s[gi]),
        .din_valid    (valid_s[gi]),
        .din_ready    (ready_s[gi]),
        .shift_out    (so_s[gi]),
        .shift_en     (en_s[gi]),
        .frame_active (fa_s[gi]),
        .done         (dn_s[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one word into instance k and check every bit cycle against
  // the hand-written transmit-order sequence.
  task automatic send_word(input int k, input logic [7:0] w, input logic seq [8], input string tag);
    din_s[k]   = w;
    valid_s[k] = 1'b1;
    tick();
    valid_s[k] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_bit"},   32'(so_s[k]),    32'(seq[i]));
      check({tag, "_en"},    32'(en_s[k]),    32'd1);
      check({tag, "_fa"},    32'(fa_s[k]),    32'd1);
      check({tag, "_ready"}, 32'(ready_s[k]), 32'd0);
      check({tag, "_done"},  32'(dn_s[k]),    32'(i == 7));
      tick();
    end
    check({tag, "_en_after"},   32'(en_s[k]), 32'd0);
    check({tag, "_done_after"}, 32'(dn_s[k]), 32'd0);
    check({tag, "_so_after"},   32'(so_s[k]), 32'd0);
    $display("tx %s dut=%0d word=%02h", tag, k, w);
  endtask

  initial begin
    logic seq_a [8];
    logic [7:0] words [3];
    logic [7:0] wv;
    int rise0, rise1, dones;
    bit prev_en;

    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      din_s[k]   = 8'h00;
      valid_s[k] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      check("idle_ready", 32'(ready_s[0]), 32'd1);
      check("idle_en",    32'(en_s[0]),    32'd0);
      check("idle_so",    32'(so_s[0]),    32'd0);
      check("idle_done",  32'(dn_s[0]),    32'd0);
      check("idle_fa",    32'(fa_s[0]),    32'd0);
      tick();
    end
    $display("tx idle_after_reset cycles=10");

    // 0x35 LSB-first, then one gap cycle, then ready again
    seq_a = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    send_word(0, 8'h35, seq_a, "lsb35");
    check("lsb35_gap_ready", 32'(ready_s[0]), 32'd0);
    check("lsb35_gap_fa",    32'(fa_s[0]),    32'd0);
    tick();
    check("lsb35_idle_ready", 32'(ready_s[0]), 32'd1);

    // 0x35 MSB-first
    seq_a = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    send_word(1, 8'h35, seq_a, "msb35");
    tick();

    // GAP=2, continuous valid: 0xFF then 0x00
    din_s[2]   = 8'hFF;
    valid_s[2] = 1'b1;
    tick();
    rise0   = -1;
    rise1   = -1;
    prev_en = 1'b0;
    for (int j = 0; j < 22; j++) begin
      check("gap2_en",    32'(en_s[2]),    32'((j <= 7) || (j >= 11 && j <= 18)));
      check("gap2_ready", 32'(ready_s[2]), 32'((j == 10) || (j == 21)));
      check("gap2_so",    32'(so_s[2]),    32'(j <= 7));
      check("gap2_done",  32'(dn_s[2]),    32'((j == 7) || (j == 18)));
      if (en_s[2] && !prev_en) begin
        if (rise0 < 0) rise0 = j;
        else if (rise1 < 0) rise1 = j;
      end
      prev_en = en_s[2];
      if (j == 0) din_s[2] = 8'h00;
      if (j == 21) valid_s[2] = 1'b0;
      tick();
    end
    check("gap2_spacing", 32'(rise1 - rise0), 32'd11);
    $display("tx gap2 words=FF,00 spacing=%0d", rise1 - rise0);

    // Reset during bit 4 of 0xA5 (LSB-first bits 1,0,1,0,0,...)
    seq_a = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    din_s[0]   = 8'hA5;
    valid_s[0] = 1'b1;
    tick();
    valid_s[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("abort_bit",  32'(so_s[0]), 32'(seq_a[i]));
      check("abort_en",   32'(en_s[0]), 32'd1);
      check("abort_done", 32'(dn_s[0]), 32'd0);
      if (i == 4) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    check("abort_so",    32'(so_s[0]),    32'd0);
    check("abort_en0",   32'(en_s[0]),    32'd0);
    check("abort_fa",    32'(fa_s[0]),    32'd0);
    check("abort_done0", 32'(dn_s[0]),    32'd0);
    check("abort_ready", 32'(ready_s[0]), 32'd1);
    $display("tx abort word=A5 at bit 4");
    seq_a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_word(0, 8'h01, seq_a, "post01");
    tick();

    // GAP=0, three back-to-back words
    words[0] = 8'h96;
    words[1] = 8'h3C;
    words[2] = 8'hF0;
    din_s[3]   = words[0];
    valid_s[3] = 1'b1;
    tick();
    dones = 0;
    for (int j = 0; j < 27; j++) begin
      wv = words[j / 9];
      check("gap0_en",    32'(en_s[3]),    32'((j % 9) != 8));
      check("gap0_ready", 32'(ready_s[3]), 32'((j % 9) == 8));
      check("gap0_done",  32'(dn_s[3]),    32'((j % 9) == 7));
      if ((j % 9) != 8) begin
        check("gap0_bit", 32'(so_s[3]), 32'(wv[j % 9]));
      end
      if (dn_s[3]) dones++;
      if (j == 8)  din_s[3] = words[1];
      if (j == 17) din_s[3] = words[2];
      if (j == 26) valid_s[3] = 1'b0;
      tick();
    end
    check("gap0_done_count", 32'(dones), 32'd3);
    check("gap0_quiet", 32'(en_s[3]), 32'd0);
    $display("tx gap0 words=96,3C,F0 dones=%0d", dones);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
